multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Main control FSM for the multi-cycle RV32I datapath: it sequences fetch, decode, execute, memory and writeback, and drives the shared ALU's 4-bit `alu_ctrl`. It consumes the ALU's `zero` flag for branch resolution. The block sits between the instruction register and the datapath muxes and enables. It owns no datapath storage; PC, IR, old-PC, ALUOut and memory-data registers live in the datapath and are gated by this block's enables.

## Interface
Parameters: none.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `instr` in 32: IR contents, valid from DECODE onward.
- `zero` in 1: ALU result == 0.
- `mem_ready` in 1: memory completes the current request this cycle.
- `alu_ctrl` out 4: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS_B.
- `alu_src_a` out 2: 0 PC, 1 old PC, 2 rs1.
- `alu_src_b` out 2: 0 rs2, 1 imm, 2 constant 4.
- `imm_src` out 3: 0 I, 1 S, 2 B, 3 U, 4 J.
- `result_src` out 2: 0 ALUOut reg, 1 mem-data reg, 2 ALU direct.
- `adr_src` out 1: 0 PC, 1 ALUOut.
- `pc_src` out 1: 0 result bus, 1 ALUOut with bit 0 cleared.
- `ir_write`, `pc_write`, `reg_write`, `mem_req`, `mem_we` out 1 each: datapath enables.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.

## Operation
- Outputs are a function of the registered state, plus `instr` and `zero` where noted. `imm_src` is decoded from the opcode in every state.
- FETCH: `mem_req`=1, `adr_src`=0. While `mem_ready`=0, hold with all write enables at 0. When `mem_ready`=1: `ir_write`=1, ALU = PC+4 (ADD, a=0, b=2), `result_src`=2, `pc_src`=0, `pc_write`=1, then go to DECODE.
- DECODE: ALU = oldPC+imm (ADD, a=1, b=1). The datapath latches this into ALUOut. Next state by opcode:
  - R-type/OP-IMM → EXEC_ALU
  - LOAD/STORE → MEM_ADR
  - BRANCH → BRANCH
  - JAL → JUMP
  - JALR → EXEC_JALR
  - LUI → EXEC_LUI
  - AUIPC → ALU_WB
  - FENCE → FETCH
  - anything else → ILLEGAL
- EXEC_ALU: a=2; b=0 for R-type, b=1 for OP-IMM. `alu_ctrl` comes from funct3 and instr[30]. SUB applies only for R-type with funct3=0. SRA/SRAI is selected by instr[30]. Next: ALU_WB.
- EXEC_LUI: PASS_B with b=1, then ALU_WB.
- ALU_WB: `result_src`=0, `reg_write`=1, then FETCH.
- MEM_ADR: ADD, a=2, b=1, then MEM_RD for loads or MEM_WR for stores.
- MEM_RD: `mem_req`=1, `adr_src`=1. Hold until `mem_ready`, then MEM_WB.
- MEM_WB: `result_src`=1, `reg_write`=1, then FETCH.
- MEM_WR: `mem_req`=1, `mem_we`=1, `adr_src`=1. Hold until `mem_ready`, then FETCH.
- BRANCH: a=2, b=0.
  - BEQ/BNE use SUB; take on `zero` / `!zero`.
  - BLT/BGE use SLT; take on `!zero` / `zero`.
  - BLTU/BGEU use SLTU; same polarity as BLT/BGE.
  - If taken: `pc_src`=1, `pc_write`=1.
  - Next: FETCH.
- JUMP: `pc_src`=1, `pc_write`=1. ALU = oldPC+4 (a=1, b=2), `result_src`=2, `reg_write`=1. Next: FETCH.
- EXEC_JALR: ADD, a=2, b=1 (into ALUOut), then JUMP.
- ILLEGAL: `illegal`=1, no writes, then FETCH. An instruction is illegal if it has:
  - an unknown opcode;
  - an R-type funct7 other than 0x00 or 0x20 (0x20 is valid only with funct3 0 or 5);
  - a shift-immediate funct7 other than 0x00, or 0x20 with funct3=5;
  - branch funct3 2 or 3;
  - load funct3 3, 6 or 7;
  - store funct3 greater than 2;
  - any SYSTEM instruction.

## Timing
- Reset: state=FETCH. All enables, `mem_req`, `mem_we` and `illegal` are 0 in the cycle `rst` is high. Mux selects reset to 0 and `alu_ctrl` to ADD.
- Cycle counts with zero-wait memory:
  - R/I/LUI: 4
  - AUIPC: 3
  - load: 5
  - store: 4
  - branch: 3
  - JAL: 3
  - JALR: 4
  - FENCE: 2
- Each wait cycle on `mem_ready` adds one cycle.
- `mem_req` stays high and the address stays stable until the `mem_ready` cycle. `mem_ready` is ignored outside FETCH, MEM_RD and MEM_WR.
- `rst` mid-instruction: the next state is FETCH and `mem_req` drops in the reset cycle. `rst` wins over a simultaneous `mem_ready`, and no write enable fires.

## Structure
- `riscv_pkg`: ALU op codes, opcode constants, state enum, and `alu_src_*`/`result_src`/`imm_src` encodings, shared with the datapath and ALU.
- Sub-module `alu_decoder` (combinational): op class (add/sub-compare/funct) + funct3 + instr[30] + is_rtype → `alu_ctrl`.

## Test plan
- Reset, then `mem_ready`=1 constant: FETCH asserts `ir_write`=`pc_write`=1, `alu_ctrl`=0, `alu_src_b`=2 in the first cycle after reset.
- SUB x3,x1,x2 (0x402081B3): sequence FETCH/DECODE/EXEC_ALU/ALU_WB, with `alu_ctrl`=1 in EXEC and `reg_write`=1 only in cycle 4. ADDI with instr[30]=1 gives `alu_ctrl`=0.
- BLT with `zero`=0, then with `zero`=1: `alu_ctrl`=8, and `pc_write` with `pc_src`=1 only in the `zero`=0 case.
- LW with `mem_ready` low for 3 cycles in MEM_RD: `mem_req`/`adr_src`=1 held, total 8 cycles, `result_src`=1 with `reg_write` at the end.
- JALR: EXEC_JALR then JUMP with `pc_src`=1, `result_src`=2, `reg_write`=1 and `pc_write`=1 in the same cycle.
- Opcode 0x7F: `illegal` pulses for exactly one cycle with no writes, then FETCH. `rst` asserted in MEM_WR with `mem_ready`=1 gives `mem_we`=0 and FETCH next.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared encodings for the multi-cycle RV32I core: ALU ops, opcodes, mux selects
// and the main control FSM states.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_XOR   = 4'd4,
    ALU_SLL   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_SLT   = 4'd8,
    ALU_SLTU  = 4'd9,
    ALU_PASSB = 4'd10
  } alu_op_e;

  typedef enum logic [1:0] {
    ACLS_ADD   = 2'd0,
    ACLS_CMP   = 2'd1,
    ACLS_FUNCT = 2'd2,
    ACLS_PASS  = 2'd3
  } alu_cls_e;

  typedef enum logic [1:0] {SRCA_PC = 2'd0, SRCA_OLDPC = 2'd1, SRCA_RS1 = 2'd2} src_a_e;
  typedef enum logic [1:0] {SRCB_RS2 = 2'd0, SRCB_IMM = 2'd1, SRCB_FOUR = 2'd2} src_b_e;
  typedef enum logic [1:0] {RES_ALUOUT = 2'd0, RES_MEMDATA = 2'd1, RES_ALU = 2'd2} res_src_e;
  typedef enum logic [2:0] {
    IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4
  } imm_src_e;

  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_IMM    = 7'h13;
  localparam logic [6:0] OP_REG    = 7'h33;
  localparam logic [6:0] OP_FENCE  = 7'h0F;
  localparam logic [6:0] OP_SYSTEM = 7'h73;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DECODE, ST_MEM_ADR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR,
    ST_EXEC_ALU, ST_EXEC_LUI, ST_EXEC_JALR, ST_ALU_WB, ST_BRANCH, ST_JUMP, ST_ILLEGAL
  } state_e;

  function automatic imm_src_e imm_sel(input logic [6:0] opcode);
    case (opcode)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_LUI, OP_AUIPC: return IMM_U;
      OP_JAL:           return IMM_J;
      default:          return IMM_I;
    endcase
  endfunction

  // SYSTEM falls into the default arm: the core has no CSR/trap support.
  function automatic logic instr_legal(input logic [6:0] opcode, input logic [2:0] f3,
                                       input logic [6:0] f7);
    case (opcode)
      OP_REG:    return (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      OP_IMM:    return (f3 == 3'd1) ? (f7 == 7'h00) :
                        (f3 == 3'd5) ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1;
      OP_BRANCH: return (f3 != 3'd2) && (f3 != 3'd3);
      OP_LOAD:   return (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      OP_STORE:  return f3 <= 3'd2;
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE: return 1'b1;
      default:   return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Maps an ALU op class plus funct3/instr[30] onto the shared ALU's 4-bit op code.
module alu_decoder
  import riscv_pkg::*;
(
  input  alu_cls_e   cls_i,
  input  logic [2:0] funct3_i,
  input  logic       instr30_i,
  input  logic       is_rtype_i,
  output alu_op_e    alu_ctrl_o
);

  always_comb begin
    alu_ctrl_o = ALU_ADD;
    case (cls_i)
      ACLS_ADD:  alu_ctrl_o = ALU_ADD;
      ACLS_PASS: alu_ctrl_o = ALU_PASSB;
      // Branch compare: funct3[2:1] picks equality / signed / unsigned.
      ACLS_CMP: begin
        case (funct3_i[2:1])
          2'b10:   alu_ctrl_o = ALU_SLT;
          2'b11:   alu_ctrl_o = ALU_SLTU;
          default: alu_ctrl_o = ALU_SUB;
        endcase
      end
      ACLS_FUNCT: begin
        case (funct3_i)
          3'd0:    alu_ctrl_o = (is_rtype_i && instr30_i) ? ALU_SUB : ALU_ADD;
          3'd1:    alu_ctrl_o = ALU_SLL;
          3'd2:    alu_ctrl_o = ALU_SLT;
          3'd3:    alu_ctrl_o = ALU_SLTU;
          3'd4:    alu_ctrl_o = ALU_XOR;
          3'd5:    alu_ctrl_o = instr30_i ? ALU_SRA : ALU_SRL;
          3'd6:    alu_ctrl_o = ALU_OR;
          default: alu_ctrl_o = ALU_AND;
        endcase
      end
      default: alu_ctrl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multi-cycle RV32I datapath: sequences fetch through
// writeback and drives mux selects, enables and the ALU op.
module multicycle_ctrl
  import riscv_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [3:0]  alu_ctrl,
  output logic [1:0]  alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [2:0]  imm_src,
  output logic [1:0]  result_src,
  output logic        adr_src,
  output logic        pc_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        mem_req,
  output logic        mem_we,
  output logic        illegal
);

  state_e   state_q, state_d;
  alu_cls_e alu_cls;
  alu_op_e  alu_op;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       is_rtype, legal, br_taken;
  logic       unused_instr;

  assign opcode       = instr[6:0];
  assign funct3       = instr[14:12];
  assign funct7       = instr[31:25];
  assign is_rtype     = (opcode == OP_REG);
  assign legal        = instr_legal(opcode, funct3, funct7);
  assign unused_instr = ^{instr[24:15], instr[11:7]};

  // Odd funct3 inverts the sense: BNE/BGE/BGEU vs BEQ/BLT/BLTU.
  always_comb begin
    if (funct3[2]) br_taken = funct3[0] ? zero : !zero;
    else           br_taken = funct3[0] ? !zero : zero;
  end

  alu_decoder u_alu_dec (
    .cls_i      (alu_cls),
    .funct3_i   (funct3),
    .instr30_i  (instr[30]),
    .is_rtype_i (is_rtype),
    .alu_ctrl_o (alu_op)
  );

  assign alu_ctrl = alu_op;

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:     if (mem_ready) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!legal) state_d = ST_ILLEGAL;
        else begin
          case (opcode)
            OP_REG, OP_IMM:     state_d = ST_EXEC_ALU;
            OP_LOAD, OP_STORE:  state_d = ST_MEM_ADR;
            OP_BRANCH:          state_d = ST_BRANCH;
            OP_JAL:             state_d = ST_JUMP;
            OP_JALR:            state_d = ST_EXEC_JALR;
            OP_LUI:             state_d = ST_EXEC_LUI;
            OP_AUIPC:           state_d = ST_ALU_WB;
            OP_FENCE:           state_d = ST_FETCH;
            default:            state_d = ST_ILLEGAL;
          endcase
        end
      end
      ST_EXEC_ALU:  state_d = ST_ALU_WB;
      ST_EXEC_LUI:  state_d = ST_ALU_WB;
      ST_ALU_WB:    state_d = ST_FETCH;
      ST_MEM_ADR:   state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:    if (mem_ready) state_d = ST_MEM_WB;
      ST_MEM_WB:    state_d = ST_FETCH;
      ST_MEM_WR:    if (mem_ready) state_d = ST_FETCH;
      ST_BRANCH:    state_d = ST_FETCH;
      ST_JUMP:      state_d = ST_FETCH;
      ST_EXEC_JALR: state_d = ST_JUMP;
      ST_ILLEGAL:   state_d = ST_FETCH;
      default:      state_d = ST_FETCH;
    endcase
  end

  // Reset forces every output to its idle value, so a reset cycle never writes.
  always_comb begin
    alu_cls    = ACLS_ADD;
    alu_src_a  = SRCA_PC;
    alu_src_b  = SRCB_RS2;
    imm_src    = IMM_I;
    result_src = RES_ALUOUT;
    adr_src    = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    illegal    = 1'b0;
    if (!rst) begin
      imm_src = imm_sel(opcode);
      case (state_q)
        ST_FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          ir_write   = mem_ready;
          pc_write   = mem_ready;
        end
        ST_DECODE: begin
          alu_src_a = SRCA_OLDPC;
          alu_src_b = SRCB_IMM;
        end
        ST_EXEC_ALU: begin
          alu_cls   = ACLS_FUNCT;
          alu_src_a = SRCA_RS1;
          alu_src_b = is_rtype ? SRCB_RS2 : SRCB_IMM;
        end
        ST_EXEC_LUI: begin
          alu_cls   = ACLS_PASS;
          alu_src_b = SRCB_IMM;
        end
        ST_ALU_WB: begin
          result_src = RES_ALUOUT;
          reg_write  = 1'b1;
        end
        ST_MEM_ADR, ST_EXEC_JALR: begin
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_IMM;
        end
        ST_MEM_RD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        ST_MEM_WB: begin
          result_src = RES_MEMDATA;
          reg_write  = 1'b1;
        end
        ST_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
        end
        ST_BRANCH: begin
          alu_cls   = ACLS_CMP;
          alu_src_a = SRCA_RS1;
          alu_src_b = SRCB_RS2;
          pc_src    = br_taken;
          pc_write  = br_taken;
        end
        ST_JUMP: begin
          alu_src_a  = SRCA_OLDPC;
          alu_src_b  = SRCB_FOUR;
          result_src = RES_ALU;
          pc_src     = 1'b1;
          pc_write   = 1'b1;
          reg_write  = 1'b1;
        end
        ST_ILLEGAL: illegal = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed-vector bench for multicycle_ctrl: walks instruction classes cycle by
// cycle and compares enables and selects against hand-computed values.
module tb_multicycle_ctrl;

  logic        clk, rst, zero, mem_ready;
  logic [31:0] instr;
  logic [3:0]  alu_ctrl;
  logic [1:0]  alu_src_a, alu_src_b, result_src;
  logic [2:0]  imm_src;
  logic        adr_src, pc_src, ir_write, pc_write, reg_write, mem_req, mem_we, illegal;
  logic [5:0]  en;
  int          n_vec = 0;
  int          n_err = 0;

  // {ir_write, pc_write, reg_write, mem_req, mem_we, illegal}
  localparam logic [5:0] EN_NONE  = 6'b000000;
  localparam logic [5:0] EN_FETCH = 6'b110100;
  localparam logic [5:0] EN_REQ   = 6'b000100;
  localparam logic [5:0] EN_WB    = 6'b001000;
  localparam logic [5:0] EN_WR    = 6'b000110;
  localparam logic [5:0] EN_PC    = 6'b010000;
  localparam logic [5:0] EN_JMP   = 6'b011000;
  localparam logic [5:0] EN_ILL   = 6'b000001;

  assign en = {ir_write, pc_write, reg_write, mem_req, mem_we, illegal};

  multicycle_ctrl dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .alu_ctrl(alu_ctrl), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .result_src(result_src), .adr_src(adr_src), .pc_src(pc_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic nx();
    @(posedge clk);
    #1;
  endtask

  // FETCH (zero-wait) then DECODE; leaves the FSM in the third cycle.
  task automatic fd(input string tag);
    smp(); chk({tag, "_f_en"}, en, EN_FETCH); nx();
    smp(); chk({tag, "_d_en"}, en, EN_NONE);  nx();
  endtask

  initial begin
    rst = 1'b1; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
    smp();
    chk("rst_en", en, EN_NONE);
    chk("rst_alu", alu_ctrl, 4'd0);
    chk("rst_srcb", alu_src_b, 2'd0);
    nx();
    rst = 1'b0;

    // SUB x3,x1,x2
    instr = 32'h402081B3;
    smp(); chk("sub_f_en", en, EN_FETCH); chk("sub_f_alu", alu_ctrl, 4'd0);
    chk("sub_f_srcb", alu_src_b, 2'd2); chk("sub_f_res", result_src, 2'd2); nx();
    smp(); chk("sub_d_en", en, EN_NONE); chk("sub_d_ab", {alu_src_a, alu_src_b}, 4'b0101); nx();
    smp(); chk("sub_x_en", en, EN_NONE); chk("sub_x_alu", alu_ctrl, 4'd1);
    chk("sub_x_ab", {alu_src_a, alu_src_b}, 4'b1000); nx();
    smp(); chk("sub_w_en", en, EN_WB); chk("sub_w_res", result_src, 2'd0); nx();

    // ADDI x1,x1,0x400 (instr[30]=1 must not turn into SUB)
    instr = 32'h40008093;
    fd("addi");
    smp(); chk("addi_x_alu", alu_ctrl, 4'd0); chk("addi_x_srcb", alu_src_b, 2'd1); nx();
    smp(); chk("addi_w_en", en, EN_WB); nx();

    // SRAI x1,x1,5
    instr = 32'h4050D093;
    fd("srai");
    smp(); chk("srai_x_alu", alu_ctrl, 4'd7); nx();
    smp(); chk("srai_w_en", en, EN_WB); nx();

    // BLT x1,x2: taken with zero=0
    instr = 32'h0020C063; zero = 1'b0;
    smp(); chk("blt0_f_en", en, EN_FETCH); nx();
    smp(); chk("blt0_d_imm", imm_src, 3'd2); nx();
    smp(); chk("blt0_b_en", en, EN_PC); chk("blt0_b_alu", alu_ctrl, 4'd8);
    chk("blt0_b_pcsrc", pc_src, 1'b1); nx();

    // BLT not taken with zero=1
    zero = 1'b1;
    fd("blt1");
    smp(); chk("blt1_b_en", en, EN_NONE); chk("blt1_b_alu", alu_ctrl, 4'd8); nx();
    zero = 1'b0;

    // LW x5,0(x1) with three wait cycles in MEM_RD: 8 cycles total
    instr = 32'h0000A283;
    fd("lw");
    smp(); chk("lw_a_en", en, EN_NONE); chk("lw_a_ab", {alu_src_a, alu_src_b}, 4'b1001);
    chk("lw_a_alu", alu_ctrl, 4'd0); nx();
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      smp(); chk("lw_rwait_en", en, EN_REQ); chk("lw_rwait_adr", adr_src, 1'b1); nx();
    end
    mem_ready = 1'b1;
    smp(); chk("lw_rdy_en", en, EN_REQ); chk("lw_rdy_adr", adr_src, 1'b1); nx();
    smp(); chk("lw_wb_en", en, EN_WB); chk("lw_wb_res", result_src, 2'd1); nx();

    // JALR x1,0(x2)
    instr = 32'h000100E7;
    fd("jalr");
    smp(); chk("jalr_x_en", en, EN_NONE); chk("jalr_x_ab", {alu_src_a, alu_src_b}, 4'b1001); nx();
    smp(); chk("jalr_j_en", en, EN_JMP); chk("jalr_j_pcsrc", pc_src, 1'b1);
    chk("jalr_j_res", result_src, 2'd2); chk("jalr_j_ab", {alu_src_a, alu_src_b}, 4'b0110); nx();

    // JAL x1: 3 cycles
    instr = 32'h000000EF;
    smp(); chk("jal_f_en", en, EN_FETCH); nx();
    smp(); chk("jal_d_imm", imm_src, 3'd4); nx();
    smp(); chk("jal_j_en", en, EN_JMP); nx();

    // LUI x5
    instr = 32'h000002B7;
    fd("lui");
    smp(); chk("lui_x_alu", alu_ctrl, 4'd10); chk("lui_x_srcb", alu_src_b, 2'd1); nx();
    smp(); chk("lui_w_en", en, EN_WB); nx();

    // AUIPC x5: straight from DECODE to writeback
    instr = 32'h00000297;
    fd("auipc");
    smp(); chk("auipc_w_en", en, EN_WB); chk("auipc_w_res", result_src, 2'd0); nx();

    // FENCE preceded by one fetch wait cycle; back in FETCH after DECODE
    instr = 32'h0000000F; mem_ready = 1'b0;
    smp(); chk("fence_fwait_en", en, EN_REQ); chk("fence_fwait_adr", adr_src, 1'b0); nx();
    mem_ready = 1'b1;
    fd("fence");

    // Undefined opcode 0x7F: single illegal pulse, then FETCH
    instr = 32'h0000007F;
    fd("op7f");
    smp(); chk("op7f_ill_en", en, EN_ILL); nx();
    instr = 32'h40001033;
    smp(); chk("op7f_after_en", en, EN_FETCH); nx();
    // R-type funct7=0x20 with funct3=1 is illegal
    smp(); chk("rf7_d_en", en, EN_NONE); nx();
    smp(); chk("rf7_ill_en", en, EN_ILL); nx();

    // ECALL (SYSTEM) is illegal
    instr = 32'h00000073;
    fd("ecall");
    smp(); chk("ecall_ill_en", en, EN_ILL); nx();

    // SW x2,0(x1): stall in MEM_WR, then reset with mem_ready=1
    instr = 32'h0020A023;
    smp(); chk("sw_f_en", en, EN_FETCH); nx();
    smp(); chk("sw_d_imm", imm_src, 3'd1); nx();
    smp(); chk("sw_a_en", en, EN_NONE); nx();
    mem_ready = 1'b0;
    smp(); chk("sw_wr_en", en, EN_WR); chk("sw_wr_adr", adr_src, 1'b1); nx();
    rst = 1'b1; mem_ready = 1'b1;
    smp(); chk("sw_rst_en", en, EN_NONE); nx();
    rst = 1'b0;
    smp(); chk("sw_rst_fetch_en", en, EN_FETCH); nx();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
